// File: rtl/pe_psum_acc_if.sv
// pe_psum_acc_if: partial-sum input stream and result output stream of the accumulator.
interface pe_psum_acc_if #(parameter int DATA_W = 32);
    logic              psum_valid;
    logic              psum_ready;
    logic [DATA_W-1:0] psum_data;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    modport master (output psum_valid, psum_data, res_ready, input psum_ready, res_valid, res_data);
    modport slave  (input psum_valid, psum_data, res_ready, output psum_ready, res_valid, res_data);
endinterface

// File: rtl/pe_psum_acc.sv
// pe_psum_acc: accumulates num_chunks partial sums into one neuron result with optional ReLU.
module pe_psum_acc #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_chunks,
    input  logic             relu_en,
    output logic             busy,
    pe_psum_acc_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q, len_q;
    logic              relu_q;
    logic              take, last;

    assign take = bus.psum_valid && state_q == ACC;
    assign last = cnt_q == len_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start) state_d = num_chunks == '0 ? DONE : ACC;
        if (take && last) state_d = DONE;
        if (state_q == DONE && bus.res_ready) state_d = IDLE;
    end

    always_comb begin
        bus.psum_ready = state_q == ACC;
        bus.res_valid  = state_q == DONE;
        bus.res_data   = (state_q == DONE && !(relu_q && acc_q[DATA_W-1])) ? acc_q : '0;
        busy           = state_q != IDLE;
    end

    // Accumulator and counter are frozen in DONE, which keeps res_data stable under backpressure.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            relu_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            len_q  <= num_chunks;
            relu_q <= relu_en;
        end else if (take) begin
            acc_q <= acc_q + bus.psum_data;
            cnt_q <= cnt_q + 1'b1;
        end
endmodule
